// File: rtl/scanout_fetch.sv
// scanout_fetch: fetches framebuffer bursts into a pixel FIFO and streams 4:4:4 RGB to the DVI pins.
// Optional macro SCANOUT_UNDERFLOW_CNT_EN adds a saturating o_underflow_cnt output.
module scanout_fetch #(
  parameter logic [26:0] BASE_ADDR   = 27'h0,
  parameter int          FRAME_WORDS = 307200,
  parameter int          BURST_LEN   = 8,
  parameter int          FIFO_DEPTH  = 32
) (
  input  logic        clk1x,
  input  logic        reset,
  input  logic        i_de,
  input  logic        i_vblank,
  output logic        o_read_req,
  output logic [26:0] o_addr,
  input  logic        i_read_ack,
  input  logic        i_read_valid,
  input  logic [15:0] i_read_data,
  output logic [3:0]  o_r,
  output logic [3:0]  o_g,
  output logic [3:0]  o_b,
  output logic        o_underflow
`ifdef SCANOUT_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] o_underflow_cnt
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int SUM_W  = CNT_W + 1;
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam logic [26:0] END_ADDR = BASE_ADDR + 27'(FRAME_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t              state_r;
  logic                read_req_r;
  logic [26:0]         addr_r;
  logic [BEAT_W-1:0]   beat_cnt_r;
  logic                drain_r;
  logic                vblank_d_r;
  logic [11:0]         fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [CNT_W-1:0]    fifo_count_r;
  logic [3:0]          r_r;
  logic [3:0]          g_r;
  logic [3:0]          b_r;
  logic                underflow_r;

  logic                flush_s;
  logic                empty_s;
  logic                pop_s;
  logic                wr_en_s;
  logic                start_s;
  logic [26:0]         next_addr_s;
  logic [11:0]         head_s;
  logic                unused_data_s;

  assign unused_data_s = ^i_read_data[15:12];
  assign head_s        = fifo_mem_r[rd_ptr_r];

  // Flush detection, FIFO handshakes and next burst address
  always_comb begin
    flush_s = i_vblank & ~vblank_d_r;
    empty_s = (fifo_count_r == CNT_W'(0));
    pop_s   = i_de & ~empty_s;
    wr_en_s = (state_r == ST_DATA) & i_read_valid & ~drain_r & ~flush_s;
    // A request is only issued when a whole burst is guaranteed to fit
    start_s = ~i_vblank & ~flush_s &
              ((SUM_W'(fifo_count_r) + SUM_W'(BURST_LEN)) <= SUM_W'(FIFO_DEPTH));
    if ((addr_r + 27'(BURST_LEN)) >= END_ADDR) begin
      next_addr_s = BASE_ADDR;
    end else begin
      next_addr_s = addr_r + 27'(BURST_LEN);
    end
  end

  // Request FSM: issue a burst, collect or drain its beats
  always_ff @(posedge clk1x) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      read_req_r <= 1'b0;
      addr_r     <= BASE_ADDR;
      beat_cnt_r <= BEAT_W'(0);
      drain_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          beat_cnt_r <= BEAT_W'(0);
          drain_r    <= 1'b0;
          if (flush_s) begin
            addr_r     <= BASE_ADDR;
            read_req_r <= 1'b0;
          end else if (start_s) begin
            state_r    <= ST_REQ;
            read_req_r <= 1'b1;
          end else begin
            read_req_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (i_read_ack) begin
            state_r    <= ST_DATA;
            read_req_r <= 1'b0;
            beat_cnt_r <= BEAT_W'(0);
            drain_r    <= flush_s;
            addr_r     <= flush_s ? BASE_ADDR : next_addr_s;
          end else if (flush_s) begin
            state_r    <= ST_IDLE;
            read_req_r <= 1'b0;
            addr_r     <= BASE_ADDR;
          end else begin
            read_req_r <= 1'b1;
          end
        end
        ST_DATA: begin
          read_req_r <= 1'b0;
          if (flush_s) begin
            addr_r  <= BASE_ADDR;
            drain_r <= 1'b1;
          end
          if (i_read_valid) begin
            if (beat_cnt_r == BEAT_W'(BURST_LEN - 1)) begin
              state_r    <= ST_IDLE;
              beat_cnt_r <= BEAT_W'(0);
              drain_r    <= 1'b0;
            end else begin
              beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
            end
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          read_req_r <= 1'b0;
          beat_cnt_r <= BEAT_W'(0);
          drain_r    <= 1'b0;
        end
      endcase
    end
  end

  // FIFO storage
  always_ff @(posedge clk1x) begin
    if (wr_en_s) begin
      fifo_mem_r[wr_ptr_r] <= i_read_data[11:0];
    end
  end

  // FIFO pointers/occupancy, pixel output register and underflow flag
  always_ff @(posedge clk1x) begin
    if (!reset) begin
      vblank_d_r   <= 1'b0;
      wr_ptr_r     <= PTR_W'(0);
      rd_ptr_r     <= PTR_W'(0);
      fifo_count_r <= CNT_W'(0);
      r_r          <= 4'h0;
      g_r          <= 4'h0;
      b_r          <= 4'h0;
      underflow_r  <= 1'b0;
    end else begin
      vblank_d_r <= i_vblank;
      if (pop_s) begin
        {b_r, g_r, r_r} <= head_s;
      end else begin
        {b_r, g_r, r_r} <= 12'h000;
      end
      if (i_de && empty_s) begin
        underflow_r <= 1'b1;
      end
      // The pop above still shows the old head; the flush then discards everything
      if (flush_s) begin
        wr_ptr_r     <= PTR_W'(0);
        rd_ptr_r     <= PTR_W'(0);
        fifo_count_r <= CNT_W'(0);
      end else begin
        if (wr_en_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        case ({wr_en_s, pop_s})
          2'b10:   fifo_count_r <= fifo_count_r + CNT_W'(1);
          2'b01:   fifo_count_r <= fifo_count_r - CNT_W'(1);
          default: fifo_count_r <= fifo_count_r;
        endcase
      end
    end
  end

`ifdef SCANOUT_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_r;

  // Saturating count of cycles that demanded a pixel from an empty FIFO
  always_ff @(posedge clk1x) begin
    if (!reset) begin
      underflow_cnt_r <= 16'h0000;
    end else if (i_de && empty_s && (underflow_cnt_r != 16'hFFFF)) begin
      underflow_cnt_r <= underflow_cnt_r + 16'h0001;
    end else begin
      underflow_cnt_r <= underflow_cnt_r;
    end
  end

  assign o_underflow_cnt = underflow_cnt_r;
`endif

  assign o_read_req  = read_req_r;
  assign o_addr      = addr_r;
  assign o_r         = r_r;
  assign o_g         = g_r;
  assign o_b         = b_r;
  assign o_underflow = underflow_r;

endmodule

// File: tb/tb_scanout_fetch.sv
// Self-checking bench for scanout_fetch: directed scenarios plus randomized traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_scanout_fetch;

  localparam logic [26:0] BASE  = 27'h0001000;
  localparam int          FRAME = 16;
  localparam int          BURST = 8;
  localparam int          DEPTH = 32;

  logic        clk1x;
  logic        reset;
  logic        i_de;
  logic        i_vblank;
  logic        o_read_req;
  logic [26:0] o_addr;
  logic        i_read_ack;
  logic        i_read_valid;
  logic [15:0] i_read_data;
  logic [3:0]  o_r;
  logic [3:0]  o_g;
  logic [3:0]  o_b;
  logic        o_underflow;
`ifdef SCANOUT_UNDERFLOW_CNT_EN
  logic [15:0] o_underflow_cnt;
`endif

  scanout_fetch #(
    .BASE_ADDR  (BASE),
    .FRAME_WORDS(FRAME),
    .BURST_LEN  (BURST),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk1x       (clk1x),
    .reset       (reset),
    .i_de        (i_de),
    .i_vblank    (i_vblank),
    .o_read_req  (o_read_req),
    .o_addr      (o_addr),
    .i_read_ack  (i_read_ack),
    .i_read_valid(i_read_valid),
    .i_read_data (i_read_data),
    .o_r         (o_r),
    .o_g         (o_g),
    .o_b         (o_b),
    .o_underflow (o_underflow)
`ifdef SCANOUT_UNDERFLOW_CNT_EN
    ,
    .o_underflow_cnt(o_underflow_cnt)
`endif
  );

  initial clk1x = 1'b0;
  always #5 clk1x = ~clk1x;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pixel queue, one outstanding-burst record, next address
  logic [11:0] m_q[$];
  bit          m_req;
  bit          m_in_burst;
  bit          m_discard;
  int          m_beats;
  logic [26:0] m_addr;
  logic [11:0] m_pix;
  bit          m_uf;
  logic [15:0] m_ufcnt;
  bit          m_prev_vb;

  function automatic logic [26:0] advance(input logic [26:0] a);
    if (a + 27'(BURST) >= BASE + 27'(FRAME)) return BASE;
    return a + 27'(BURST);
  endfunction

  task automatic model_step();
    int sz0;
    bit rise;
    bit wr;
    if (!reset) begin
      m_q.delete();
      m_req = 0; m_in_burst = 0; m_discard = 0; m_beats = 0;
      m_addr = BASE; m_pix = 12'h000; m_uf = 0; m_ufcnt = 16'h0000; m_prev_vb = 0;
      return;
    end
    sz0 = m_q.size();
    rise = i_vblank && !m_prev_vb;
    m_prev_vb = i_vblank;
    wr = 0;
    if (m_in_burst) begin
      wr = i_read_valid && !m_discard && !rise;
      if (rise) begin m_addr = BASE; m_discard = 1; end
      if (i_read_valid) begin
        m_beats--;
        if (m_beats == 0) begin m_in_burst = 0; m_discard = 0; end
      end
    end else if (m_req) begin
      if (i_read_ack) begin
        m_req = 0; m_in_burst = 1; m_beats = BURST; m_discard = rise;
        m_addr = rise ? BASE : advance(m_addr);
      end else if (rise) begin
        m_req = 0; m_addr = BASE;
      end
    end else begin
      if (rise) m_addr = BASE;
      else if (!i_vblank && (sz0 + BURST <= DEPTH)) m_req = 1;
    end
    if (i_de && sz0 > 0) m_pix = m_q.pop_front();
    else m_pix = 12'h000;
    if (i_de && sz0 == 0) begin
      m_uf = 1;
      if (m_ufcnt != 16'hFFFF) m_ufcnt++;
    end
    if (wr) m_q.push_back(i_read_data[11:0]);
    if (rise) m_q.delete();
  endtask

  always @(posedge clk1x) model_step();

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk1x) begin
    if (chk_en) begin
      chk("read_req", o_read_req, m_req);
      chk("addr", o_addr, m_addr);
      chk("rgb", {o_b, o_g, o_r}, m_pix);
      chk("underflow", o_underflow, m_uf);
`ifdef SCANOUT_UNDERFLOW_CNT_EN
      chk("underflow_cnt", o_underflow_cnt, m_ufcnt);
`endif
    end
  end

  logic [26:0] acc[$];
  logic [26:0] exp_acc[4];
  int pend;
  int waited;
  bit first;

  initial begin
    reset = 1'b0; i_de = 1'b0; i_vblank = 1'b0;
    i_read_ack = 1'b0; i_read_valid = 1'b0; i_read_data = 16'h0000;
    repeat (3) @(negedge clk1x);
    chk_en = 1'b1;
    chk("rst_req", o_read_req, 32'd0);
    chk("rst_addr", o_addr, 32'h1000);
    chk("rst_rgb", {o_b, o_g, o_r}, 32'd0);
    chk("rst_uf", o_underflow, 32'd0);
    reset = 1'b1;

    // Fill: immediate acks and back-to-back beats until the FIFO is full
    pend = 0; first = 1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk1x);
      i_read_valid = (pend > 0);
      i_read_data = first ? 16'hFA53 : 16'($urandom);
      if (i_read_valid) begin pend--; first = 0; end
      i_read_ack = m_req;
      if (m_req) begin acc.push_back(o_addr); pend += BURST; end
    end
    exp_acc[0] = 27'h1000; exp_acc[1] = 27'h1008;
    exp_acc[2] = 27'h1000; exp_acc[3] = 27'h1008;
    chk("fill_req_count", acc.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("fill_addr", (i < acc.size()) ? acc[i] : 27'h7FFFFFF, exp_acc[i]);
    chk("full_no_req", o_read_req, 32'd0);

    // Head pixel 0x0A53 popped by one DE cycle
    @(negedge clk1x); i_de = 1'b1;
    @(negedge clk1x); i_de = 1'b0;
    chk("head_r", o_r, 32'h3);
    chk("head_g", o_g, 32'h5);
    chk("head_b", o_b, 32'hA);

    // Drain the rest, then three DE cycles on an empty FIFO
    for (int c = 0; c < 31; c++) begin @(negedge clk1x); i_de = 1'b1; end
    @(negedge clk1x);
    chk("no_uf_yet", o_underflow, 32'd0);
    i_de = 1'b1;
    @(negedge clk1x); i_de = 1'b1;
    @(negedge clk1x); i_de = 1'b1;
    @(negedge clk1x); i_de = 1'b0;
    chk("uf_rgb", {o_b, o_g, o_r}, 32'd0);
    chk("uf_flag", o_underflow, 32'd1);
`ifdef SCANOUT_UNDERFLOW_CNT_EN
    chk("uf_cnt", o_underflow_cnt, 32'd3);
`endif

    // Flush after 3 of 8 beats
    @(negedge clk1x);
    chk("pending_req", o_read_req, 32'd1);
    i_read_ack = m_req;
    @(negedge clk1x);
    i_read_ack = 1'b0;
    chk("addr_after_accept", o_addr, 32'h1008);
    i_read_valid = 1'b1; i_read_data = 16'h0FFF;
    @(negedge clk1x);
    @(negedge clk1x);
    @(negedge clk1x); i_read_valid = 1'b0; i_vblank = 1'b1;
    for (int c = 0; c < 5; c++) begin @(negedge clk1x); i_read_valid = 1'b1; end
    @(negedge clk1x); i_read_valid = 1'b0; i_de = 1'b1;
    chk("addr_after_flush", o_addr, 32'h1000);
    @(negedge clk1x); i_de = 1'b0;
    chk("flushed_empty", {o_b, o_g, o_r}, 32'd0);
    i_vblank = 1'b0;
    waited = 0;
    while (!o_read_req && waited < 10) begin @(negedge clk1x); waited++; end
    chk("req_after_flush", o_read_req, 32'd1);
    chk("addr_req_after_flush", o_addr, 32'h1000);

    // Reset in the middle of a burst, followed by stray beats
    @(negedge clk1x); i_read_ack = m_req;
    @(negedge clk1x); i_read_ack = 1'b0; i_read_valid = 1'b1; i_read_data = 16'($urandom);
    @(negedge clk1x); i_read_data = 16'($urandom);
    @(negedge clk1x); reset = 1'b0;
    @(negedge clk1x); reset = 1'b1;
    chk("midrst_req", o_read_req, 32'd0);
    chk("midrst_addr", o_addr, 32'h1000);
    chk("midrst_rgb", {o_b, o_g, o_r}, 32'd0);
    chk("midrst_uf", o_underflow, 32'd0);
    for (int c = 0; c < 5; c++) begin @(negedge clk1x); i_read_data = 16'($urandom); end
    @(negedge clk1x); i_read_valid = 1'b0; i_de = 1'b1;
    @(negedge clk1x); i_de = 1'b0;
    chk("stray_not_written", {o_b, o_g, o_r}, 32'd0);
    chk("stray_uf", o_underflow, 32'd1);

    // Randomized traffic
    pend = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk1x);
      reset = ($urandom_range(0, 599) != 0);
      i_de = ($urandom_range(0, 3) != 0);
      if (i_vblank) i_vblank = ($urandom_range(0, 9) != 0);
      else i_vblank = ($urandom_range(0, 149) == 0);
      if (pend > 0) begin
        i_read_valid = ($urandom_range(0, 3) != 0);
        if (i_read_valid) pend--;
      end else begin
        i_read_valid = ($urandom_range(0, 19) == 0);
      end
      i_read_data = 16'($urandom);
      i_read_ack = m_req && ($urandom_range(0, 2) != 0);
      if (i_read_ack) pend += BURST;
    end
    @(negedge clk1x);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scanout_fetch.md
SCANOUT_FETCH -- requirements
Module: scanout_fetch

Interface
REQ-001 Parameter BASE_ADDR, default 27'h0, word address of framebuffer pixel 0.
REQ-002 Parameter FRAME_WORDS, default 307200, 16-bit words per frame (640x480, one word per pixel).
REQ-003 Parameter BURST_LEN, default 8, words returned per read request; power of two.
REQ-004 Parameter FIFO_DEPTH, default 32, pixel FIFO entries; power of two, >= 2*BURST_LEN.
REQ-005 clk1x  input  1  pixel clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-low.
REQ-007 i_de  input  1  active-video strobe from beam_position.
REQ-008 i_vblank  input  1  high during vertical blanking.
REQ-009 o_read_req  output  1  read request to the memory controller.
REQ-010 o_addr  output  27  burst start word address, same bank/row/column packing the controller consumes.
REQ-011 i_read_ack  input  1  controller accepts the request this cycle.
REQ-012 i_read_valid  input  1  one read-data beat valid.
REQ-013 i_read_data  input  16  read-data beat; [3:0]=R, [7:4]=G, [11:8]=B, [15:12] ignored.
REQ-014 o_r, o_g, o_b  output  4 each  pixel colour to DVI pins.
REQ-015 o_underflow  output  1  sticky flag: pixel demanded while FIFO empty.

Function
REQ-016 FSM states IDLE, REQ, DATA; no other states shall be reachable.
REQ-017 IDLE->REQ when i_vblank low, no flush pending, and (fifo_count + BURST_LEN) <= FIFO_DEPTH.
REQ-018 In REQ, o_read_req high and o_addr stable until the cycle i_read_ack is high; then move to DATA, o_read_req low next cycle.
REQ-019 In DATA, each i_read_valid beat writes one FIFO entry; after BURST_LEN beats return to IDLE.
REQ-020 i_read_valid outside DATA shall be ignored.
REQ-021 After each accepted request, o_addr += BURST_LEN; when the next address reaches BASE_ADDR+FRAME_WORDS it wraps to BASE_ADDR.
REQ-022 Rising edge of i_vblank (flush): FIFO emptied, o_addr = BASE_ADDR, o_read_req dropped, FSM to IDLE next cycle.
REQ-023 Flush during DATA: remaining beats of the in-flight burst are counted and discarded, not written; FSM stays in a drain sub-condition of DATA until count completes, then IDLE.
REQ-024 Flush in same cycle as i_read_ack: request counts as accepted; its beats are discarded per REQ-023.
REQ-025 Pixel pop: when i_de high and FIFO non-empty, pop one entry; o_r/o_g/o_b show it exactly 1 cycle later.
REQ-026 i_de low: o_r/o_g/o_b = 0 next cycle; no pop.
REQ-027 i_de high and FIFO empty: no pop, outputs 0 next cycle, o_underflow set.
REQ-028 Simultaneous FIFO write and pop: both occur, fifo_count unchanged; write never drops data since REQ-017 reserves space.
REQ-029 fifo_count width log2(FIFO_DEPTH)+1; no overflow or wrap of the count is permitted.

Reset
REQ-030 While reset low: FSM IDLE, FIFO empty, o_read_req 0, o_addr BASE_ADDR, o_r/o_g/o_b 0, o_underflow 0, beat counters 0.
REQ-031 Reset mid-burst aborts the burst; beats arriving after reset release outside DATA are ignored (REQ-020).
REQ-032 o_underflow clears only on reset.

Configuration
REQ-033 Macro SCANOUT_UNDERFLOW_CNT_EN defined: extra output o_underflow_cnt [15:0], increments per underflow cycle, saturates at 16'hFFFF, clears on reset only.
REQ-034 Macro undefined: port o_underflow_cnt and its counter absent; all other behaviour identical.

Verification
REQ-035 Reset, i_vblank low, ack immediately -> o_read_req high with o_addr=BASE_ADDR, next request at BASE_ADDR+8, stops requesting at fifo_count=32 (4 bursts).
REQ-036 FIFO holding 0x0A53 at head, i_de high one cycle -> next cycle o_r=3, o_g=5, o_b=A.
REQ-037 FIFO empty, i_de high 3 cycles -> o_rgb=0, o_underflow=1, o_underflow_cnt=3 (macro defined).
REQ-038 i_vblank rises after 3 of 8 beats -> next 5 beats discarded, fifo_count=0, next request o_addr=BASE_ADDR.
REQ-039 FRAME_WORDS=16, BURST_LEN=8, continuous drain -> addresses BASE, BASE+8, BASE, BASE+8...
REQ-040 reset low during DATA after 2 beats -> all outputs at REQ-030 values next cycle; stray beats not written.
